// File: rtl/pw_pkg.sv
// pw_pkg: shared definitions for the period/pulse-width sequencing controller.
// Provides the generator/counter width, repeat-count width, program depth,
// the controller state encoding and the program entry record.
package pw_pkg;

  localparam int W     = 11;
  localparam int REP_W = 8;
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // One program step: period n, pulse width mt, pulses in the step rep.
  typedef struct packed {
    logic [W-1:0]     n;
    logic [W-1:0]     mt;
    logic [REP_W-1:0] rep;
  } entry_t;

endpackage

// File: rtl/pw_seq_tab.sv
// pw_seq_tab: 4-entry program register file for pw_seq_ctrl.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wr_en, wr_addr      table write strobe and entry index
//   wr_N, wr_MT, wr_rep values for the written entry
//   err_clr             clears the sticky error (accepted start)
//   cur_idx, nxt_idx    read addresses for the current and next step
//   cur, nxt            read data for those two addresses
//   err                 sticky flag, set by any write that fails validation
module pw_seq_tab
  import pw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [W-1:0]     wr_N,
  input  logic [W-1:0]     wr_MT,
  input  logic [REP_W-1:0] wr_rep,
  input  logic             err_clr,
  input  logic [1:0]       cur_idx,
  input  logic [1:0]       nxt_idx,
  output entry_t           cur,
  output entry_t           nxt,
  output logic             err
);

  entry_t tab [DEPTH];
  logic   valid;

  // A step is usable only if the pulse fits strictly inside the period and
  // emits at least one pulse.
  assign valid = (wr_MT != '0) && (wr_MT < wr_N) && (wr_rep != '0);

  assign cur = tab[cur_idx];
  assign nxt = tab[nxt_idx];

  // Table storage and error flag. A bad write sets err even in the same
  // cycle as a clear, so no invalid write is ever silently forgotten.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab[i] <= '{n: W'(2), mt: W'(1), rep: REP_W'(1)};
      end
      err <= 1'b0;
    end else begin
      if (wr_en && valid) begin
        tab[wr_addr] <= '{n: wr_N, mt: wr_MT, rep: wr_rep};
      end
      if (wr_en && !valid) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pw_seq_ctrl.sv
// pw_seq_ctrl: sequencing controller for the N/MT pulse-width generator.
// Runs a 4-step (period, width, repeat) program once or in a loop, switching
// steps only on pulse starts, and stops on a pulse's falling edge.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr_en/wr_addr/wr_N/wr_MT/wr_rep  program table write
//   last, loop                   final step index and wrap mode (sampled at start)
//   start, stop                  run request and graceful stop request
//   q, start_PW, end_PW          generator count and strobes
//   N, MT, ce                    generator configuration and enable
//   busy, done, step, err        status outputs
module pw_seq_ctrl
  import pw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [W-1:0]     wr_N,
  input  logic [W-1:0]     wr_MT,
  input  logic [REP_W-1:0] wr_rep,
  input  logic [1:0]       last,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic [W-1:0]     q,
  input  logic             start_PW,
  input  logic             end_PW,
  output logic [W-1:0]     N,
  output logic [W-1:0]     MT,
  output logic             ce,
  output logic             busy,
  output logic             done,
  output logic [1:0]       step,
  output logic             err
);

  state_t           state;
  logic [REP_W-1:0] rem;
  logic [1:0]       last_r;
  logic             loop_r;
  logic             stop_pend;
  logic             counted;
  logic             err_clr;
  logic [1:0]       cur_idx;
  logic [1:0]       nxt_idx;
  entry_t           cur;
  entry_t           nxt;
  logic [REP_W-1:0] run_rem;
  logic [1:0]       run_step;
  logic             run_drain;

  assign counted = ce & start_PW;
  assign err_clr = (state == IDLE) & start;
  // In IDLE the step register may hold the index of a finished run, but a
  // new run always begins from entry 0.
  assign cur_idx = (state == IDLE) ? 2'd0 : step;
  assign nxt_idx = (step == last_r) ? 2'd0 : step + 2'd1;

  pw_seq_tab u_tab (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_N    (wr_N),
    .wr_MT   (wr_MT),
    .wr_rep  (wr_rep),
    .err_clr (err_clr),
    .cur_idx (cur_idx),
    .nxt_idx (nxt_idx),
    .cur     (cur),
    .nxt     (nxt),
    .err     (err)
  );

  // Effect of a counted edge in RUN: either consume one pulse of the current
  // step, or (step exhausted) let this pulse open the next step. The drain
  // test looks at the values after that update.
  always_comb begin
    run_rem   = rem;
    run_step  = step;
    run_drain = 1'b0;
    if (counted) begin
      if (rem != '0) begin
        run_rem = rem - REP_W'(1);
      end else begin
        run_step = nxt_idx;
        run_rem  = nxt.rep - REP_W'(1);
      end
      run_drain = (run_rem == '0) && (run_step == last_r) && !loop_r;
    end
  end

  // Controller FSM with registered outputs. N is seeded from q on start so
  // the generator sees q==N in ARM and begins the first pulse immediately,
  // whatever count it was frozen at.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      N         <= '0;
      MT        <= '0;
      ce        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= '0;
      rem       <= '0;
      last_r    <= '0;
      loop_r    <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            N         <= q;
            MT        <= cur.mt;
            rem       <= cur.rep;
            step      <= '0;
            ce        <= 1'b1;
            busy      <= 1'b1;
            last_r    <= last;
            loop_r    <= loop;
            stop_pend <= 1'b0;
            state     <= ARM;
          end
        end
        ARM: begin
          N         <= cur.n;
          rem       <= rem - REP_W'(1);
          stop_pend <= stop;
          if ((rem == REP_W'(1)) && (last_r == 2'd0) && !loop_r) begin
            state <= DRAIN;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          rem  <= run_rem;
          step <= run_step;
          if (counted && (rem == '0)) begin
            N  <= nxt.n;
            MT <= nxt.mt;
          end
          if (run_drain || stop || stop_pend) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ce && end_PW) begin
            ce        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_pend <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pw_seq_ctrl.md
# pw_seq_ctrl

Sequencing controller for the period/pulse-width generator (the `N`/`MT` counter block with `start_PW`/`end_PW` strobes). It holds a 4-entry program of (period, width, repeat) steps and drives the generator's `N`, `MT` and `ce`. Steps are switched only on pulse boundaries, so every emitted pulse is glitch-free. It can run a program once or loop it, and it stops cleanly on a pulse's falling edge.

## Interface
- `W`, 11: width of `N`, `MT` and generator `q`.
- `REP_W`, 8: width of the repeat count.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  2  table entry index.
- `wr_N`, `wr_MT`  in  W  period and pulse width for the entry.
- `wr_rep`  in  REP_W  pulses in the step (≥1).
- `last`  in  2  index of the final program step, sampled at `start`.
- `loop`  in  1  wrap `last`→0 instead of finishing, sampled at `start`.
- `start`  in  1  run request.
- `stop`  in  1  graceful stop request.
- `q`  in  W  generator count.
- `start_PW`, `end_PW`  in  1  generator strobes.
- `N`, `MT`  out  W  generator configuration.
- `ce`  out  1  generator enable.
- `busy`  out  1  not IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `step`  out  2  current table index.
- `err`  out  1  sticky invalid-write flag.

## Operation
- Table write is accepted only if 1 ≤ `wr_MT` < `wr_N` and `wr_rep` ≠ 0.
  - An invalid write is dropped and sets `err`.
  - `err` clears on `rst` or on an accepted `start`.
  - Writes are allowed at any time. A written value takes effect when its entry is next loaded.
- State `IDLE`:
  - `ce`=0; the generator is frozen.
  - `start` loads `N`←`q`, `MT`←MT[0], `rem`←rep[0], `step`←0, `ce`←1, and goes to `ARM`.
  - `stop` is ignored in `IDLE`.
- State `ARM`:
  - `q`==`N`, so `start_PW`=1 and the first pulse begins on this edge.
  - On that edge: `N`←N[0], `rem`←`rem`-1, go to `RUN`.
- State `RUN`. A counted edge is `ce`&`start_PW`; each one begins a pulse.
  - If `rem`≠0: `rem`←`rem`-1.
  - If `rem`=0 (step exhausted): the pulse belongs to the next step. Set `step`←next (`last`→0 when `loop`), load `N`,`MT` from it, and set `rem`←rep-1.
  - The new `MT` sets this pulse's width. The new `N` sets the gap after it. The gap before it used the old `N`.
- Drain condition: after any counted edge, if `rem` becomes 0, `step`=`last` and `loop`=0, go to `DRAIN`.
- A `stop` in `ARM`/`RUN` also goes to `DRAIN`. If it arrives in `ARM`, it is latched and takes effect once in `RUN`.
- State `DRAIN`:
  - Counted edges do not change `rem`/`step`.
  - On `ce`&`end_PW`: `ce`←0, `done`←1 for one cycle, go to `IDLE`.
  - The generator is left with `PW`=0 and `q`=MT+1.
- Simultaneous events:
  - `start` while busy is ignored.
  - `start` and `stop` together in `IDLE`: `start` wins.
  - `end_PW` and `start_PW` together in `DRAIN` (MT=N, impossible with a validated table): end wins.

## Timing
- Reset values:
  - `N`=0, `MT`=0, `ce`=0, `busy`=0, `done`=0, `step`=0, `err`=0, state `IDLE`, `rem`=0.
  - Table entries reset to N=2, MT=1, rep=1.
- `rst` mid-run returns all of the above on the next edge. The generator then freezes with whatever `PW` it held.
- Start latency:
  - `ce` rises 1 cycle after `start`.
  - The generator `PW` rises 2 cycles after `start`, independent of `q`.
- Period in `RUN` is `N` cycles between `PW` rises; the `PW` high time is `MT` cycles.
- `done` asserts 1 cycle after the final `end_PW`-qualified edge, in the same cycle `ce` is 0.
- `busy` is registered from state.

## Structure
- Shared package `pw_pkg`:
  - constants `W`=11, `REP_W`=8, `DEPTH`=4;
  - state encoding `IDLE`/`ARM`/`RUN`/`DRAIN`;
  - entry record (N, MT, rep).
- Sub-module `pw_seq_tab`: the 4-entry register file with the write validator and `err`, two read ports (current and next entry).

## Test plan
- Entry0 = {5,2,3}, `last`=0, `loop`=0, `start` at `q`=0 -> `PW` rises at cycles 2/7/12, each 2 cycles high; `done` one cycle after the third fall; `ce`=0 afterwards.
- Entries 0={4,1,2}, 1={6,3,1}, `last`=1 -> `PW` widths 1,1,3; rise spacing 4,4; `step` changes to 1 on the third rise; `done` after width-3 pulse.
- `loop`=1 with 0={3,1,1}, 1={5,2,1}, `stop` at cycle 20 -> pattern alternates; `ce` drops exactly on the first `PW` fall after cycle 20; `PW`=0 at stop.
- Write {3,3,1} and {3,1,0} -> both dropped, `err`=1, table unchanged; next `start` clears `err`.
- `rst` asserted mid-`RUN` -> next cycle all outputs at reset values; re-`start` with frozen `q`=9, N[0]=4 -> `PW` still rises 2 cycles later.
- `start` with `stop` in `IDLE`, then `start` during `RUN` -> run begins; second `start` has no effect on `step`/`rem`.
